// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Receive side of the host/player radio link. Deserializes 8N1 UART frames
// (LSB first) into bytes and hands them to the game FSM through a
// ready/acknowledge pair. Framing and overrun problems are reported as
// sticky flags.
//
// Parameters
//   CLKS_PER_BIT : system clocks per bit time (>= 4)
//
// Ports
//   clk         : system clock, rising edge
//   nRst        : asynchronous active-low reset
//   rx_serial   : serial line, idle high, asynchronous to clk
//   ack         : consumer has taken rx_data
//   rx_data     : last valid byte received
//   data_ready  : rx_data holds an unacknowledged byte
//   framing_err : last frame's stop bit sampled low (sticky)
//   overrun_err : a byte was overwritten before it was acknowledged (sticky)
//   busy        : receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx_serial,
  input  logic       ack,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_rxData;
  logic            r_dataReady;
  logic            r_framingErr;
  logic            r_overrunErr;
  logic            r_busy;

  logic            w_rxS;
  logic            w_cntClr;
  logic            w_idxClr;
  logic            w_shift;
  logic            w_load;
  logic            w_frameErr;

  assign w_rxS = r_sync[1];

  // Two-flop synchronizer; resets to the idle (high) line level so that
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx_serial};
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_cntClr    = 1'b0;
    w_idxClr    = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_frameErr  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cntClr = 1'b1;
        if (!w_rxS) w_nextState = START;
      end
      START: begin
        // Mid-start-bit check: a line that is already high again was a glitch.
        if (r_cnt == HALF_M1) begin
          w_cntClr = 1'b1;
          w_idxClr = 1'b1;
          w_nextState = w_rxS ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cntClr = 1'b1;
          w_shift  = 1'b1;
          if (r_idx == 3'd7) w_nextState = STOP;
        end
      end
      STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cntClr = 1'b1;
          if (w_rxS) begin
            w_load      = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_frameErr  = 1'b1;
            w_nextState = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not be decoded as repeated 0x00 frames.
        w_cntClr = 1'b1;
        if (w_rxS) w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      if (w_cntClr) r_cnt <= '0;
      else          r_cnt <= r_cnt + CW'(1);

      if (w_idxClr)     r_idx <= 3'd0;
      else if (w_shift) r_idx <= r_idx + 3'd1;

      if (w_shift) r_shift <= {w_rxS, r_shift[7:1]};
    end
  end

  // A new byte landing on the same edge as ack wins: the byte stays pending
  // and any previous overrun is considered acknowledged.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_rxData     <= 8'h00;
      r_dataReady  <= 1'b0;
      r_framingErr <= 1'b0;
      r_overrunErr <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_nextState != IDLE);
      if (w_load) begin
        r_rxData     <= r_shift;
        r_dataReady  <= 1'b1;
        r_framingErr <= 1'b0;
        if (r_dataReady && !ack)     r_overrunErr <= 1'b1;
        else if (r_dataReady && ack) r_overrunErr <= 1'b0;
      end else begin
        if (w_frameErr) r_framingErr <= 1'b1;
        if (ack && r_dataReady) begin
          r_dataReady  <= 1'b0;
          r_overrunErr <= 1'b0;
        end
      end
    end
  end

  assign rx_data     = r_rxData;
  assign data_ready  = r_dataReady;
  assign framing_err = r_framingErr;
  assign overrun_err = r_overrunErr;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx with CLKS_PER_BIT = 8. Every byte that
// should be delivered is pushed to a scoreboard queue when its frame is
// driven; a monitor pops and compares whenever the receiver presents a new
// byte. Directed checks cover latency, glitches, framing errors, overrun,
// ack on the completion edge and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk;
  logic       nRst;
  logic       rxSerial;
  logic       ack;
  logic [7:0] rxData;
  logic       dataReady;
  logic       framingErr;
  logic       overrunErr;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] sbQ[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .rx_serial  (rxSerial),
    .ack        (ack),
    .rx_data    (rxData),
    .data_ready (dataReady),
    .framing_err(framingErr),
    .overrun_err(overrunErr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 frame starting at the current negedge; leaves the line
  // at the stop-bit level when done.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic expectByte);
    logic [9:0] bits;
    bits = {stopBit, data, 1'b0};
    if (expectByte) sbQ.push_back(data);
    for (int b = 0; b < 10; b++) begin
      rxSerial = bits[b];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic pulseAck();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic idle(input int n);
    rxSerial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: a new byte is a rising data_ready or a changed
  // rx_data while data_ready stays high.
  logic       prevReady = 1'b0;
  logic [7:0] prevData  = 8'h00;
  always @(negedge clk) begin
    if (dataReady === 1'b1 && (prevReady !== 1'b1 || rxData !== prevData)) begin
      checkOutput("sbNonEmpty", 32'(sbQ.size() > 0), 32'd1);
      if (sbQ.size() > 0) checkOutput("sbByte", 32'(rxData), 32'(sbQ.pop_front()));
    end
    prevReady = dataReady;
    prevData  = rxData;
  end

  initial begin
    int busyLow;
    logic sawBusy;
    nRst = 1'b0;
    rxSerial = 1'b1;
    ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstData", 32'(rxData), 32'h00);
    checkOutput("rstReady", 32'(dataReady), 32'd0);
    checkOutput("rstFrm", 32'(framingErr), 32'd0);
    checkOutput("rstOvr", 32'(overrunErr), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    nRst = 1'b1;
    idle(5);

    // 1. clean byte with exact latency and busy coverage
    busyLow = 0;
    fork
      applyStimulus(8'h41, 1'b1, 1'b1);
      begin
        for (int k = 1; k <= 79; k++) begin
          @(negedge clk);
          if (k >= 3 && k <= 78 && busy !== 1'b1) busyLow++;
          if (k == 78) checkOutput("latEarly", 32'(dataReady), 32'd0);
          if (k == 79) begin
            checkOutput("latReady", 32'(dataReady), 32'd1);
            checkOutput("latData", 32'(rxData), 32'h41);
            checkOutput("cleanBusyEnd", 32'(busy), 32'd0);
          end
        end
      end
    join
    checkOutput("cleanBusyFrame", 32'(busyLow), 32'd0);
    checkOutput("cleanFrm", 32'(framingErr), 32'd0);
    checkOutput("cleanOvr", 32'(overrunErr), 32'd0);
    idle(3);
    pulseAck();
    checkOutput("ackReady", 32'(dataReady), 32'd0);
    checkOutput("ackData", 32'(rxData), 32'h41);
    idle(5);

    // 2. glitch rejection
    sawBusy = 1'b0;
    rxSerial = 1'b0;
    repeat (2) @(negedge clk);
    rxSerial = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy === 1'b1) sawBusy = 1'b1;
    end
    checkOutput("glitchBusyPulse", 32'(sawBusy), 32'd1);
    checkOutput("glitchBusyEnd", 32'(busy), 32'd0);
    checkOutput("glitchReady", 32'(dataReady), 32'd0);
    checkOutput("glitchFrm", 32'(framingErr), 32'd0);
    checkOutput("glitchData", 32'(rxData), 32'h41);

    // 3. framing error, break, recovery
    applyStimulus(8'h50, 1'b0, 1'b0);
    rxSerial = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("frmErr", 32'(framingErr), 32'd1);
    checkOutput("frmReady", 32'(dataReady), 32'd0);
    checkOutput("frmData", 32'(rxData), 32'h41);
    checkOutput("frmBreakBusy", 32'(busy), 32'd1);
    idle(10);
    checkOutput("frmSticky", 32'(framingErr), 32'd1);
    applyStimulus(8'h4C, 1'b1, 1'b1);
    idle(2);
    checkOutput("recData", 32'(rxData), 32'h4C);
    checkOutput("recReady", 32'(dataReady), 32'd1);
    checkOutput("recFrm", 32'(framingErr), 32'd0);
    pulseAck();
    idle(5);

    // 4. overrun with back-to-back frames
    applyStimulus(8'h50, 1'b1, 1'b1);
    applyStimulus(8'h4C, 1'b1, 1'b1);
    idle(2);
    checkOutput("ovrData", 32'(rxData), 32'h4C);
    checkOutput("ovrReady", 32'(dataReady), 32'd1);
    checkOutput("ovrErr", 32'(overrunErr), 32'd1);
    pulseAck();
    checkOutput("ovrAckReady", 32'(dataReady), 32'd0);
    checkOutput("ovrAckErr", 32'(overrunErr), 32'd0);
    idle(5);

    // 5. ack on the stop-sample edge of the next frame
    applyStimulus(8'h45, 1'b1, 1'b1);
    idle(5);
    fork
      applyStimulus(8'h48, 1'b1, 1'b1);
      begin
        repeat (78) @(negedge clk);
        pulseAck();
      end
    join
    idle(2);
    checkOutput("coData", 32'(rxData), 32'h48);
    checkOutput("coReady", 32'(dataReady), 32'd1);
    checkOutput("coOvr", 32'(overrunErr), 32'd0);
    pulseAck();
    idle(5);

    // 6. reset during data bit 3
    fork
      applyStimulus(8'h41, 1'b1, 1'b0);
      begin
        repeat (35) @(negedge clk);
        nRst = 1'b0;
        #1;
        checkOutput("midRstData", 32'(rxData), 32'h00);
        checkOutput("midRstReady", 32'(dataReady), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstFrm", 32'(framingErr), 32'd0);
        checkOutput("midRstOvr", 32'(overrunErr), 32'd0);
      end
    join
    idle(2);
    checkOutput("holdRstBusy", 32'(busy), 32'd0);
    nRst = 1'b1;
    idle(100);
    checkOutput("postRstReady", 32'(dataReady), 32'd0);
    checkOutput("postRstFrm", 32'(framingErr), 32'd0);
    applyStimulus(8'h41, 1'b1, 1'b1);
    idle(2);
    checkOutput("postRstData", 32'(rxData), 32'h41);
    checkOutput("postRstReady2", 32'(dataReady), 32'd1);

    idle(5);
    checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive end of the wireless link between the host and player boards. It deserializes 8N1 UART frames arriving from the radio module into bytes: the ASCII guess letter on the host side, and the secret-word characters or the game-state byte on the player side. It hands each byte to the game FSM through a ready/acknowledge pair and reports framing and overrun errors. It is the counterpart of the transmitter that raises `msg_sent`.

## Interface

- `CLKS_PER_BIT`, default 1250, system clocks per bit time (12 MHz / 9600 baud). Must be ≥ 4. `HALF` = `CLKS_PER_BIT/2`, using integer division.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `nRst` input, 1 bit: asynchronous, active-low reset.
- `rx_serial` input, 1 bit: serial line, idle high, asynchronous to `clk`.
- `ack` input, 1 bit: consumer has taken `rx_data`.
- `rx_data` output, 8 bits: last valid byte received.
- `data_ready` output, 1 bit: `rx_data` holds an unacknowledged byte (level).
- `framing_err` output, 1 bit: the last frame's stop bit sampled 0 (sticky).
- `overrun_err` output, 1 bit: a byte was overwritten before it was acknowledged (sticky).
- `busy` output, 1 bit: the FSM is in any state other than IDLE.

## Operation

- **Synchronizer:** `rx_serial` passes through 2 flip-flops; both reset to 1. Every mention of "line" below means the synchronized signal `rx_s`.
- **Counters:** a bit counter of $clog2(`CLKS_PER_BIT`) bits and a 3-bit data-bit index. The shift register shifts right; LSB is received first.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:** when the line is 0, go to START and clear the counter.
- **START:** when the counter reaches `HALF`-1, sample the line.
  - Line 0: go to DATA, clear counter and index.
  - Line 1: the start was a glitch. Return to IDLE with no flag change.
- **DATA:** when the counter reaches `CLKS_PER_BIT`-1, sample the line into bit[index] and clear the counter.
  - After index 7, go to STOP.
- **STOP:** when the counter reaches `CLKS_PER_BIT`-1, sample the line.
  - Line 1: the frame is valid. Load `rx_data` from the shift register, set `data_ready`, clear `framing_err`, go to IDLE.
    - If `data_ready` was already 1 and `ack` is not high this cycle, also set `overrun_err`.
  - Line 0: set `framing_err`. Leave `rx_data` and `data_ready` unchanged. Go to WAIT_HIGH.
- **WAIT_HIGH:** stay until the line is 1, then go to IDLE. This prevents a break condition from being read as a stream of 0x00 frames.
- **ack:**
  - When `data_ready` is 1, `ack` clears `data_ready` and `overrun_err` on the next edge.
  - When `data_ready` is 0, `ack` has no effect.
- **Simultaneous valid-stop and ack:** the new byte wins. `data_ready` stays 1 with the new `rx_data`, `overrun_err` is not set, and an existing `overrun_err` is cleared.
- `busy` is 0 only in IDLE.

## Timing

- **Reset values:**
  - `rx_data` = 0x00
  - `data_ready` = 0
  - `framing_err` = 0
  - `overrun_err` = 0
  - `busy` = 0
  - state = IDLE
  - synchronizer = 1,1
- **Reset mid-frame:** asserting `nRst` at any time takes effect immediately. The partial byte is discarded and no flag is raised on release.
- **Sample instants:** let E0 be the edge at which IDLE first sees line = 0.
  - Start-bit check: E0+`HALF`.
  - Data bit k (k = 0..7): E0+`HALF`+(k+1)·`CLKS_PER_BIT`.
  - Stop bit: E0+`HALF`+9·`CLKS_PER_BIT`.
- **Latency:** `data_ready` is high after the stop-sample edge. From the first edge sampling the pin low, that is 2+`HALF`+9·`CLKS_PER_BIT` cycles; with `CLKS_PER_BIT`=8 this is 78 cycles.
- **Back-to-back frames:** IDLE is re-entered on the stop-sample edge, so a start bit may immediately follow half a stop bit. Back-to-back frames are received without loss.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

All scenarios use `CLKS_PER_BIT`=8.

1. **Clean byte:** send 0x41 ('A') as 8N1 (each bit 8 cycles).
   - `rx_data`=0x41 and `data_ready`=1 exactly 78 cycles after the start edge.
   - `framing_err`=`overrun_err`=0. `busy` is 1 throughout the frame.
   - Assert `ack` for 1 cycle: `data_ready`=0 on the next edge, `rx_data` stays 0x41.
2. **Glitch rejection:** hold `rx_serial` low for 2 cycles, then high.
   - `busy` pulses, then returns to IDLE.
   - `data_ready`, `framing_err` and `rx_data` are unchanged, with no byte emitted.
3. **Framing error and recovery:** send 0x50 ('P') with stop bit = 0, then hold low 40 cycles, then high.
   - `framing_err`=1, `data_ready`=0, `rx_data` unchanged.
   - No frame is decoded while the line is low.
   - Then send 0x4C ('L'): `rx_data`=0x4C, `data_ready`=1, `framing_err`=0.
4. **Overrun:** send 0x50 then 0x4C back-to-back with no `ack`.
   - `rx_data`=0x4C, `data_ready`=1, `overrun_err`=1.
   - `ack` clears both `data_ready` and `overrun_err`.
5. **ack on completion edge:** with 0x45 pending, pulse `ack` on the exact stop-sample edge of the next frame 0x48.
   - `rx_data`=0x48, `data_ready`=1, `overrun_err`=0.
6. **Reset mid-frame:** assert `nRst` during data bit 3 of 0x41.
   - All outputs hold their reset values while reset is asserted.
   - After release with the line idle: no `data_ready`.
   - A following 0x41 frame is received correctly.
